// File: rtl/wb_regfile.sv
// Write-back register, 32x32 integer register file and busy scoreboard for the RV32I core.
// Optional operand bypass from the write-back register: define WB_BYPASS_EN.
module wb_regfile (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        stall_in,
    input  logic        rdE_in,
    input  logic [4:0]  rdIdx_in,
    input  logic [31:0] rdData_in,
    input  logic        rs1E_in,
    input  logic        rs2E_in,
    input  logic [4:0]  rs1Idx_in,
    input  logic [4:0]  rs2Idx_in,
    output logic [31:0] rs1Data_out,
    output logic [31:0] rs2Data_out,
    input  logic        issueE_in,
    input  logic [4:0]  issueIdx_in,
    output logic        hazard_out,
    output logic        wbE_out,
    output logic [4:0]  wbIdx_out,
    output logic [31:0] wbData_out
);

    localparam int DATA_W = 32;
    localparam int IDX_W  = 5;
    localparam int NREG   = 32;

`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              wb_vld_p1;
    logic [IDX_W-1:0]  wb_idx_p1;
    logic [DATA_W-1:0] wb_data_p1;
    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:1]   busy_q;
    logic [NREG-1:0]   busy_vec;
    logic              commit;
    logic              rs1_fwd;
    logic              rs2_fwd;
    logic              raw1;
    logic              raw2;
    logic              waw;
    logic              issue_ok;

    function automatic logic fwd_match(input logic vld, input logic [IDX_W-1:0] wb_idx,
                                       input logic [IDX_W-1:0] idx);
        return BYPASS && vld && (wb_idx == idx);
    endfunction

    function automatic logic [DATA_W-1:0] read_port(input logic en, input logic [IDX_W-1:0] idx,
                                                    input logic fwd, input logic [DATA_W-1:0] wb_data,
                                                    input logic [DATA_W-1:0] arr_data);
        if (!en || idx == '0)
            return '0;
        else if (fwd)
            return wb_data;
        else
            return arr_data;
    endfunction

    assign busy_vec = {busy_q, 1'b0};
    assign commit   = wb_vld_p1 && !stall_in;

    // Stage p1: write-back register, loaded from the upstream result triple
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wb_vld_p1  <= 1'b0;
            wb_idx_p1  <= '0;
            wb_data_p1 <= '0;
        end else if (!stall_in) begin
            wb_vld_p1  <= rdE_in && (rdIdx_in != '0);
            wb_idx_p1  <= rdIdx_in;
            wb_data_p1 <= rdData_in;
        end
    end

    // Stage p2: commit into the register array
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (commit && wb_idx_p1 != '0) begin
            regs[wb_idx_p1] <= wb_data_p1;
        end
    end

    // A set from a new issue outranks a clear from a same-index commit
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (issue_ok && issueIdx_in == IDX_W'(i))
                    busy_q[i] <= 1'b1;
                else if (commit && wb_idx_p1 == IDX_W'(i))
                    busy_q[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        rs1_fwd     = fwd_match(wb_vld_p1, wb_idx_p1, rs1Idx_in);
        rs2_fwd     = fwd_match(wb_vld_p1, wb_idx_p1, rs2Idx_in);
        rs1Data_out = read_port(rs1E_in, rs1Idx_in, rs1_fwd, wb_data_p1, regs[rs1Idx_in]);
        rs2Data_out = read_port(rs2E_in, rs2Idx_in, rs2_fwd, wb_data_p1, regs[rs2Idx_in]);
        raw1        = rs1E_in && (rs1Idx_in != '0) && busy_vec[rs1Idx_in] && !rs1_fwd;
        raw2        = rs2E_in && (rs2Idx_in != '0) && busy_vec[rs2Idx_in] && !rs2_fwd;
        waw         = issueE_in && busy_vec[issueIdx_in] &&
                      !(commit && wb_idx_p1 == issueIdx_in);
        hazard_out  = raw1 || raw2 || waw;
        issue_ok    = issueE_in && (issueIdx_in != '0) && !hazard_out;
    end

    assign wbE_out    = wb_vld_p1;
    assign wbIdx_out  = wb_idx_p1;
    assign wbData_out = wb_data_p1;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed testbench for wb_regfile; expectations follow the WB_BYPASS_EN build setting.
module tb_wb_regfile;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        stall_in;
    logic        rdE_in;
    logic [4:0]  rdIdx_in;
    logic [31:0] rdData_in;
    logic        rs1E_in, rs2E_in;
    logic [4:0]  rs1Idx_in, rs2Idx_in;
    logic [31:0] rs1Data_out, rs2Data_out;
    logic        issueE_in;
    logic [4:0]  issueIdx_in;
    logic        hazard_out;
    logic        wbE_out;
    logic [4:0]  wbIdx_out;
    logic [31:0] wbData_out;

    int checks = 0;
    int errors = 0;

    wb_regfile dut (
        .clk_in(clk_in), .rst_in(rst_in), .stall_in(stall_in),
        .rdE_in(rdE_in), .rdIdx_in(rdIdx_in), .rdData_in(rdData_in),
        .rs1E_in(rs1E_in), .rs2E_in(rs2E_in), .rs1Idx_in(rs1Idx_in), .rs2Idx_in(rs2Idx_in),
        .rs1Data_out(rs1Data_out), .rs2Data_out(rs2Data_out),
        .issueE_in(issueE_in), .issueIdx_in(issueIdx_in), .hazard_out(hazard_out),
        .wbE_out(wbE_out), .wbIdx_out(wbIdx_out), .wbData_out(wbData_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        stall_in = 0; rdE_in = 0; rdIdx_in = 0; rdData_in = 0;
        rs1E_in = 0; rs2E_in = 0; rs1Idx_in = 0; rs2Idx_in = 0;
        issueE_in = 0; issueIdx_in = 0;
    endtask

    task automatic test_reset();
        rst_in = 0;
        idle();
        rs1E_in = 1; rs1Idx_in = 5;
        repeat (2) tick();
        checks++; if (rs1Data_out !== 32'h0) begin errors++; $display("FAIL reset_rs1: got %h want %h", rs1Data_out, 32'h0); end
        checks++; if (wbE_out !== 1'b0) begin errors++; $display("FAIL reset_wbE: got %b want 0", wbE_out); end
        checks++; if (hazard_out !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b want 0", hazard_out); end
        checks++; if ({wbIdx_out, wbData_out} !== 37'h0) begin errors++; $display("FAIL reset_wbreg: got %h/%h want 0/0", wbIdx_out, wbData_out); end
        #2 rst_in = 1;
        #1;
        checks++; if (rs1Data_out !== 32'h0 || wbE_out !== 1'b0) begin errors++; $display("FAIL reset_release: got %h/%b want 0/0", rs1Data_out, wbE_out); end
        tick();
        idle();
    endtask

    task automatic test_basic_write();
        rdE_in = 1; rdIdx_in = 3; rdData_in = 32'hDEADBEEF;
        tick();
        rdE_in = 0; rs1E_in = 1; rs1Idx_in = 3; rs2E_in = 0; rs2Idx_in = 3;
        #1;
        checks++; if (wbE_out !== 1'b1 || wbIdx_out !== 5'd3 || wbData_out !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_wbreg: got %b/%0d/%h want 1/3/deadbeef", wbE_out, wbIdx_out, wbData_out); end
        checks++; if (rs1Data_out !== (BYP ? 32'hDEADBEEF : 32'h0)) begin errors++; $display("FAIL basic_cycle1: got %h want %h", rs1Data_out, BYP ? 32'hDEADBEEF : 32'h0); end
        tick();
        checks++; if (rs1Data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_cycle2: got %h want deadbeef", rs1Data_out); end
        checks++; if (rs2Data_out !== 32'h0) begin errors++; $display("FAIL basic_rs2_disabled: got %h want 0", rs2Data_out); end
        checks++; if (wbE_out !== 1'b0) begin errors++; $display("FAIL basic_wbE_drop: got %b want 0", wbE_out); end
        idle();
    endtask

    task automatic test_x0();
        rdE_in = 1; rdIdx_in = 0; rdData_in = 32'h12345678;
        tick();
        rdE_in = 0; rs1E_in = 1; rs1Idx_in = 0;
        #1;
        checks++; if (wbE_out !== 1'b0) begin errors++; $display("FAIL x0_wbE: got %b want 0", wbE_out); end
        checks++; if (rs1Data_out !== 32'h0) begin errors++; $display("FAIL x0_read: got %h want 0", rs1Data_out); end
        issueE_in = 1; issueIdx_in = 0;
        #1;
        checks++; if (hazard_out !== 1'b0) begin errors++; $display("FAIL x0_issue_hazard: got %b want 0", hazard_out); end
        tick();
        tick();
        checks++; if (hazard_out !== 1'b0) begin errors++; $display("FAIL x0_reissue_hazard: got %b want 0", hazard_out); end
        tick();
        checks++; if (rs1Data_out !== 32'h0) begin errors++; $display("FAIL x0_read_after: got %h want 0", rs1Data_out); end
        idle();
    endtask

    task automatic test_raw();
        issueE_in = 1; issueIdx_in = 7;
        #1;
        checks++; if (hazard_out !== 1'b0) begin errors++; $display("FAIL raw_issue_free: got %b want 0", hazard_out); end
        tick();
        issueE_in = 0; rs2E_in = 1; rs2Idx_in = 7;
        #1;
        checks++; if (hazard_out !== 1'b1) begin errors++; $display("FAIL raw_busy: got %b want 1", hazard_out); end
        // an issue to x12 while the hazard is up must be dropped
        issueE_in = 1; issueIdx_in = 12;
        tick();
        issueE_in = 0; rs2E_in = 0; rs1E_in = 1; rs1Idx_in = 12;
        #1;
        checks++; if (hazard_out !== 1'b0) begin errors++; $display("FAIL raw_issue_ignored: got %b want 0", hazard_out); end
        rs1E_in = 0; rs2E_in = 1;
        rdE_in = 1; rdIdx_in = 7; rdData_in = 32'h00000077;
        #1;
        checks++; if (hazard_out !== 1'b1) begin errors++; $display("FAIL raw_upstream: got %b want 1", hazard_out); end
        tick();
        rdE_in = 0;
        #1;
        checks++; if (hazard_out !== (BYP ? 1'b0 : 1'b1)) begin errors++; $display("FAIL raw_wbhold: got %b want %b", hazard_out, !BYP); end
        checks++; if (rs2Data_out !== (BYP ? 32'h77 : 32'h0)) begin errors++; $display("FAIL raw_wbhold_data: got %h want %h", rs2Data_out, BYP ? 32'h77 : 32'h0); end
        tick();
        checks++; if (hazard_out !== 1'b0 || rs2Data_out !== 32'h77) begin errors++; $display("FAIL raw_committed: got %b/%h want 0/77", hazard_out, rs2Data_out); end
        idle();
    endtask

    task automatic test_waw();
        issueE_in = 1; issueIdx_in = 9;
        tick();
        #1;
        checks++; if (hazard_out !== 1'b1) begin errors++; $display("FAIL waw_second_issue: got %b want 1", hazard_out); end
        tick();
        issueE_in = 0; rs1E_in = 1; rs1Idx_in = 9;
        #1;
        checks++; if (hazard_out !== 1'b1) begin errors++; $display("FAIL waw_still_busy: got %b want 1", hazard_out); end
        rs1E_in = 0;
        rdE_in = 1; rdIdx_in = 9; rdData_in = 32'h99;
        tick();
        rdE_in = 0; issueE_in = 1; issueIdx_in = 9;
        #1;
        checks++; if (hazard_out !== 1'b0) begin errors++; $display("FAIL waw_commit_same_cycle: got %b want 0", hazard_out); end
        tick();
        issueE_in = 0; rs1E_in = 1; rs1Idx_in = 9;
        #1;
        checks++; if (hazard_out !== 1'b1) begin errors++; $display("FAIL waw_set_wins: got %b want 1", hazard_out); end
        checks++; if (rs1Data_out !== 32'h99) begin errors++; $display("FAIL waw_committed_data: got %h want 99", rs1Data_out); end
        rdE_in = 1; rdIdx_in = 9; rdData_in = 32'h9A;
        tick();
        rdE_in = 0;
        tick();
        checks++; if (hazard_out !== 1'b0 || rs1Data_out !== 32'h9A) begin errors++; $display("FAIL waw_cleared: got %b/%h want 0/9a", hazard_out, rs1Data_out); end
        idle();
    endtask

    task automatic test_stall();
        issueE_in = 1; issueIdx_in = 4;
        tick();
        issueE_in = 0;
        rdE_in = 1; rdIdx_in = 4; rdData_in = 32'hA5A5A5A5;
        tick();
        stall_in = 1; rdIdx_in = 5; rdData_in = 32'h55;
        issueE_in = 1; issueIdx_in = 13;
        #1;
        checks++; if (hazard_out !== 1'b0) begin errors++; $display("FAIL stall_issue_free: got %b want 0", hazard_out); end
        tick();
        issueE_in = 0; rs2E_in = 1; rs2Idx_in = 13;
        #1;
        checks++; if (hazard_out !== 1'b1) begin errors++; $display("FAIL stall_busy_set: got %b want 1", hazard_out); end
        rs2E_in = 0; rs1E_in = 1; rs1Idx_in = 4;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (wbE_out !== 1'b1 || wbIdx_out !== 5'd4 || wbData_out !== 32'hA5A5A5A5) begin errors++; $display("FAIL stall_hold_%0d: got %b/%0d/%h want 1/4/a5a5a5a5", c, wbE_out, wbIdx_out, wbData_out); end
            checks++; if (rs1Data_out !== (BYP ? 32'hA5A5A5A5 : 32'h0)) begin errors++; $display("FAIL stall_read_%0d: got %h want %h", c, rs1Data_out, BYP ? 32'hA5A5A5A5 : 32'h0); end
            checks++; if (hazard_out !== !BYP) begin errors++; $display("FAIL stall_hazard_%0d: got %b want %b", c, hazard_out, !BYP); end
            if (c < 2) tick();
        end
        rdE_in = 0; stall_in = 0;
        tick();
        checks++; if (rs1Data_out !== 32'hA5A5A5A5 || hazard_out !== 1'b0) begin errors++; $display("FAIL stall_commit: got %h/%b want a5a5a5a5/0", rs1Data_out, hazard_out); end
        checks++; if (wbE_out !== 1'b0) begin errors++; $display("FAIL stall_wb_drained: got %b want 0", wbE_out); end
        idle();
    endtask

    task automatic test_back_to_back();
        rdE_in = 1; rdIdx_in = 6; rdData_in = 32'h1;
        tick();
        rdData_in = 32'h2;
        tick();
        rdData_in = 32'h3;
        rs1E_in = 1; rs1Idx_in = 6;
        #1;
        checks++; if (wbData_out !== 32'h2 || rs1Data_out !== (BYP ? 32'h2 : 32'h1)) begin errors++; $display("FAIL b2b_mid: got %h/%h want 2/%h", wbData_out, rs1Data_out, BYP ? 32'h2 : 32'h1); end
        tick();
        rdE_in = 0;
        tick();
        checks++; if (rs1Data_out !== 32'h3) begin errors++; $display("FAIL b2b_last_wins: got %h want 3", rs1Data_out); end
        idle();
    endtask

    task automatic test_async_reset();
        rdE_in = 1; rdIdx_in = 20; rdData_in = 32'hCAFE;
        tick();
        rdE_in = 0; rs1E_in = 1; rs1Idx_in = 6; rs2E_in = 1; rs2Idx_in = 13;
        #2 rst_in = 0;
        #1;
        checks++; if (wbE_out !== 1'b0 || wbData_out !== 32'h0) begin errors++; $display("FAIL arst_wbreg: got %b/%h want 0/0", wbE_out, wbData_out); end
        checks++; if (rs1Data_out !== 32'h0) begin errors++; $display("FAIL arst_regs: got %h want 0", rs1Data_out); end
        checks++; if (hazard_out !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", hazard_out); end
        tick();
        rst_in = 1;
        idle();
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_x0();
        test_raw();
        test_waw();
        test_stall();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
